csi2_tx_lane_distributor: RTL and testbench
===========================================

# csi2_tx_lane_distributor

Downstream of the CSI-2 packetizer byte stream and upstream of the per-lane D-PHY serializers, this block frames each packet as one D-PHY high-speed (HS) burst. For each packet it runs HS-prepare, sends a sync byte on every lane, and stripes payload bytes round-robin across LANES lanes. It then runs HS-trail and returns to LP. It replaces the single-stream hand-off to the serializer stub with a per-lane byte interface that has a lane-valid mask.

## Interface
- LANES, 4, active lane count; legal values 1, 2, 4
- HS_PREP_CYCLES, 4, cycles of HS-prepare before sync; ≥1
- HS_TRAIL_CYCLES, 4, cycles of HS-trail after last data word; ≥1
- clk  in  1  byte clock; all logic is rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- s_axis_tdata  in  8  packet byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when tvalid&&tready
- s_axis_tlast  in  1  last byte of packet
- s_axis_tuser  in  1  frame start; meaningful on the first byte of a packet
- m_lane_data  out  8*LANES  lane i occupies bits [8i+7:8i]
- m_lane_valid  out  LANES  per-lane byte qualifier
- m_hs_req  out  1  lanes in HS (prepare through trail)
- m_frame_start  out  1  one-cycle pulse with the first data word of a packet whose first byte carried tuser

## Operation
- FSM states and transitions:
  - IDLE → PREP on s_axis_tvalid.
  - PREP holds for HS_PREP_CYCLES, then → SYNC.
  - SYNC lasts 1 cycle, then → DATA.
  - DATA → TRAIL after the word containing the tlast byte is emitted.
  - TRAIL holds for HS_TRAIL_CYCLES, then → EXIT.
  - EXIT lasts 1 cycle, then → IDLE.
- s_axis_tready=1 only in DATA, and is forced to 0 in the cycle after tlast is accepted. Output has no backpressure.
- m_hs_req=1 in PREP, SYNC, DATA and TRAIL; 0 in IDLE and EXIT.
- PREP: m_lane_data=0, m_lane_valid=0.
- SYNC: all lanes 8'hB8, m_lane_valid all ones.
- DATA: accepted byte k of the packet (k from 0) goes to lane k mod LANES.
  - A word is emitted when LANES bytes have been gathered, or on tlast.
  - Partial final word of n bytes: m_lane_valid = low n bits set; unused lanes carry 8'h00.
  - Between words m_lane_valid=0 and m_lane_data holds its last value.
- tvalid gaps inside DATA are tolerated: the partial word is held, nothing is emitted, and the FSM stays in DATA with no timeout.
- Per-lane last-MSB register:
  - Loaded with 1 at SYNC (MSB of 0xB8).
  - Updated from bit 7 of each valid byte on that lane.
- TRAIL: lane i drives {8{~last_msb[i]}}, m_lane_valid=0.
- m_frame_start: tuser is latched with byte 0 and pulses alongside the first emitted data word.

## Timing
- All outputs reset to 0; FSM resets to IDLE; partial word and counters are cleared.
- Burst timeline with tvalid rising in IDLE at cycle 0:
  - m_hs_req=1 from cycle 1.
  - SYNC at cycle 1+HS_PREP_CYCLES.
  - tready=1 from cycle 2+HS_PREP_CYCLES.
- Word latency: the word appears on m_lane_data the cycle after its last byte is accepted.
- TRAIL starts the cycle after the final word is emitted; EXIT follows TRAIL; IDLE follows EXIT. A new packet cannot begin PREP before IDLE.
- tvalid asserted during TRAIL or EXIT is ignored until IDLE, with tready=0.
- Reset asserted mid-burst: outputs go to 0 asynchronously, the packet is dropped, and m_hs_req deasserts immediately.
- LANES=1: every accepted byte is emitted as its own word with m_lane_valid=1.

## Configuration
- CSI2_TX_LANE_STATS_EN defined: adds two outputs.
  - stat_pkt_count [15:0]: increments at each DATA→TRAIL transition.
  - stat_byte_count [31:0]: increments per accepted byte.
  - Both wrap modulo 2^width and reset to 0.
- CSI2_TX_LANE_STATS_EN undefined: those ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package csi2_tx_pkg holds:
  - the state enum (IDLE, PREP, SYNC, DATA, TRAIL, EXIT);
  - the constant CSI2_SYNC_BYTE = 8'hB8;
  - the trail-byte function.
- Sub-module csi2_tx_lane_packer assembles bytes into LANES-wide words. It owns the byte index, the partial-word register and mask generation, and signals word_done/word_last to the FSM.

## Test plan
- LANES=4, 8-byte packet, tvalid continuous:
  - PREP lasts 4 cycles, then one SYNC cycle with 0xB8 on all lanes.
  - Two words are emitted with mask 4'b1111.
  - Trail lasts 4 cycles, then m_hs_req drops.
- LANES=4, 6-byte packet 01..06:
  - Word 1 is 04030201 with mask 1111.
  - Word 2 has lanes 0/1 = 05/06, lanes 2/3 = 00, mask 0011.
- Last byte on lane 0 = 0x80, other lanes' last bytes < 0x80:
  - TRAIL lane 0 = 0x00; lanes 1-3 = 0xFF.
- tvalid gap of 5 cycles mid-word:
  - No word is emitted during the gap and m_hs_req stays 1.
  - Bytes arriving after the gap complete the held word.
- rst_n pulsed in DATA:
  - All outputs are 0 in the same cycle.
  - The next packet starts a clean PREP, with byte 0 on lane 0.
- tuser=1 on byte 0 of packet A, tuser=0 on packet B:
  - m_frame_start pulses once, with A's first word only.

Source files
------------

// File: rtl/csi2_tx_pkg.sv
// Shared types and constants for the CSI-2 TX lane distributor.
// Holds the burst FSM state enum, the D-PHY sync byte and the trail-byte helper.
package csi2_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StSync,
        StData,
        StTrail,
        StExit
    } state_e;

    localparam logic [7:0] CSI2_SYNC_BYTE = 8'hB8;

    // HS-trail drives the complement of the last transmitted bit on the lane.
    function automatic logic [7:0] trail_byte(input logic last_msb);
        return {8{~last_msb}};
    endfunction

endpackage

// File: rtl/csi2_tx_lane_packer.sv
// Gathers accepted bytes into LANES-wide words, lane k mod LANES, and emits
// each word (with its lane mask) the cycle after its final byte is accepted.
module csi2_tx_lane_packer
    import csi2_tx_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_sync,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    output logic [8*LANES-1:0]   word,
    output logic [LANES-1:0]     mask,
    output logic                 word_done,
    output logic                 word_last
);

    localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [IdxW-1:0]      idx_q;
    logic [8*LANES-1:0]   partial_q;
    logic [8*LANES-1:0]   word_q;
    logic [8*LANES-1:0]   merged;
    logic [LANES-1:0]     mask_q;
    logic [LANES-1:0]     merged_mask;
    logic                 done_q;
    logic                 last_q;
    logic                 word_end;

    // Lanes above idx stay zero because the partial word is cleared per word.
    always_comb begin
        merged      = partial_q;
        merged_mask = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (idx_q == IdxW'(i)) begin
                merged[8*i +: 8] = byte_data;
            end
            if (IdxW'(i) <= idx_q) begin
                merged_mask[i] = 1'b1;
            end
        end
    end

    assign word_end = (idx_q == IdxW'(LANES - 1)) || byte_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            partial_q <= '0;
            word_q    <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            last_q <= 1'b0;
            if (load_sync) begin
                idx_q     <= '0;
                partial_q <= '0;
                word_q    <= {LANES{CSI2_SYNC_BYTE}};
            end else if (byte_valid) begin
                if (word_end) begin
                    word_q    <= merged;
                    mask_q    <= merged_mask;
                    done_q    <= 1'b1;
                    last_q    <= byte_last;
                    idx_q     <= '0;
                    partial_q <= '0;
                end else begin
                    partial_q <= merged;
                    idx_q     <= idx_q + 1'b1;
                end
            end
        end
    end

    assign word      = word_q;
    assign mask      = done_q ? mask_q : '0;
    assign word_done = done_q;
    assign word_last = last_q;

endmodule

// File: rtl/csi2_tx_lane_distributor.sv
// Frames each packetizer packet as one D-PHY HS burst and stripes bytes across lanes.
// Define CSI2_TX_LANE_STATS_EN to add packet/byte statistics counters.
module csi2_tx_lane_distributor
    import csi2_tx_pkg::*;
#(
    parameter int unsigned LANES           = 4,
    parameter int unsigned HS_PREP_CYCLES  = 4,
    parameter int unsigned HS_TRAIL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [8*LANES-1:0]   m_lane_data,
    output logic [LANES-1:0]     m_lane_valid,
    output logic                 m_hs_req,
    output logic                 m_frame_start
`ifdef CSI2_TX_LANE_STATS_EN
    ,
    output logic [15:0]          stat_pkt_count,
    output logic [31:0]          stat_byte_count
`endif
);

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [LANES-1:0]     last_msb_q;
    logic                 first_byte_q;
    logic                 first_word_q;
    logic                 user_q;
    logic                 accept;
    logic [8*LANES-1:0]   word;
    logic [LANES-1:0]     word_mask;
    logic                 word_done;
    logic                 word_last;
    logic [8*LANES-1:0]   trail_data;

    assign accept = s_axis_tvalid && s_axis_tready;

    csi2_tx_lane_packer #(
        .LANES (LANES)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_sync  (state_q == StSync),
        .byte_valid (accept),
        .byte_data  (s_axis_tdata),
        .byte_last  (s_axis_tlast),
        .word       (word),
        .mask       (word_mask),
        .word_done  (word_done),
        .word_last  (word_last)
    );

    always_comb begin
        trail_data = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            trail_data[8*i +: 8] = trail_byte(last_msb_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        m_hs_req      = 1'b0;
        m_lane_data   = '0;
        m_lane_valid  = '0;
        s_axis_tready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_axis_tvalid) begin
                    state_d = StPrep;
                    cnt_d   = '0;
                end
            end
            StPrep: begin
                m_hs_req = 1'b1;
                if (cnt_q == 16'(HS_PREP_CYCLES - 1)) begin
                    state_d = StSync;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSync: begin
                m_hs_req     = 1'b1;
                m_lane_data  = {LANES{CSI2_SYNC_BYTE}};
                m_lane_valid = '1;
                state_d      = StData;
            end
            StData: begin
                m_hs_req     = 1'b1;
                m_lane_data  = word;
                m_lane_valid = word_mask;
                // Final word is on the bus this cycle; block the next packet's bytes.
                s_axis_tready = !(word_done && word_last);
                if (word_done && word_last) begin
                    state_d = StTrail;
                    cnt_d   = '0;
                end
            end
            StTrail: begin
                m_hs_req    = 1'b1;
                m_lane_data = trail_data;
                if (cnt_q == 16'(HS_TRAIL_CYCLES - 1)) begin
                    state_d = StExit;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StExit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_msb_q   <= '0;
            first_byte_q <= 1'b0;
            first_word_q <= 1'b0;
            user_q       <= 1'b0;
        end else begin
            if (state_q == StSync) begin
                last_msb_q   <= '1;
                first_byte_q <= 1'b1;
                first_word_q <= 1'b1;
            end else begin
                if (accept && first_byte_q) begin
                    user_q       <= s_axis_tuser;
                    first_byte_q <= 1'b0;
                end
                if (word_done) begin
                    first_word_q <= 1'b0;
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (word_mask[i]) begin
                            last_msb_q[i] <= word[8*i+7];
                        end
                    end
                end
            end
        end
    end

    assign m_frame_start = word_done && first_word_q && user_q;

`ifdef CSI2_TX_LANE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkt_count  <= '0;
            stat_byte_count <= '0;
        end else begin
            if (state_q == StData && state_d == StTrail) begin
                stat_pkt_count <= stat_pkt_count + 16'd1;
            end
            if (accept) begin
                stat_byte_count <= stat_byte_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csi2_tx_lane_distributor.sv
// Scoreboard bench for csi2_tx_lane_distributor (LANES=4, 4-cycle prepare/trail).
// The driver pushes modelled words per packet; a monitor pops and compares them.
module tb_csi2_tx_lane_distributor;

    localparam int unsigned LANES = 4;
    localparam int unsigned PREP  = 4;
    localparam int unsigned TRAIL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [31:0] m_lane_data;
    logic [3:0]  m_lane_valid;
    logic        m_hs_req;
    logic        m_frame_start;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        fs;
        logic        last;
        logic [31:0] trail;
    } word_t;

    word_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] pkt [0:15];

    always #5 clk = ~clk;

    csi2_tx_lane_distributor #(
        .LANES           (LANES),
        .HS_PREP_CYCLES  (PREP),
        .HS_TRAIL_CYCLES (TRAIL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_lane_data   (m_lane_data),
        .m_lane_valid  (m_lane_valid),
        .m_hs_req      (m_hs_req),
        .m_frame_start (m_frame_start)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_model(input int len, input logic user);
        logic [3:0]  msb;
        logic [31:0] trail;
        logic [31:0] cur;
        logic [3:0]  m;
        bit          first;
        word_t       w;
        int          lane;
        msb   = 4'hF;
        trail = '0;
        cur   = '0;
        m     = '0;
        first = 1'b1;
        for (int k = 0; k < len; k++) begin
            msb[k % 4] = pkt[k][7];
        end
        for (int i = 0; i < 4; i++) begin
            trail[8*i +: 8] = {8{~msb[i]}};
        end
        for (int k = 0; k < len; k++) begin
            lane = k % 4;
            cur[8*lane +: 8] = pkt[k];
            m[lane] = 1'b1;
            if (lane == 3 || k == len - 1) begin
                w.data  = cur;
                w.mask  = m;
                w.fs    = first && user;
                w.last  = (k == len - 1);
                w.trail = trail;
                exp_q.push_back(w);
                first = 1'b0;
                cur   = '0;
                m     = '0;
            end
        end
    endtask

    task automatic send_pkt(input int len, input logic user, input int gap_at, input int abort_at);
        int   k;
        int   wait_cnt;
        bit   gap_done;
        logic acc;
        push_model(len, user);
        k        = 0;
        wait_cnt = 0;
        gap_done = 1'b0;
        while (k < len) begin
            if (k == abort_at) begin
                s_axis_tvalid = 1'b0;
                exp_q.delete();
                #2 rst_n = 1'b0;
                #1;
                check_val("abort_hs_req", m_hs_req, 0);
                check_val("abort_valid", m_lane_valid, 0);
                check_val("abort_data", m_lane_data, 0);
                check_val("abort_tready", s_axis_tready, 0);
                check_val("abort_fs", m_frame_start, 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
            if (k == gap_at && !gap_done) begin
                gap_done = 1'b1;
                s_axis_tvalid = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_val("gap_hs_req", m_hs_req, 1);
                    @(posedge clk);
                    #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pkt[k];
            s_axis_tlast  = (k == len - 1);
            s_axis_tuser  = (k == 0) ? user : 1'b0;
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt > 64) begin
                    check_val("tready_timeout", 0, 1);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Output monitor: prepare length, sync word, data words, trail bytes and length.
    initial begin
        bit          seen_sync;
        bit          in_trail;
        int          prep_cnt;
        int          trail_cnt;
        logic [31:0] cur_trail;
        word_t       w;
        seen_sync = 1'b0;
        in_trail  = 1'b0;
        prep_cnt  = 0;
        trail_cnt = 0;
        cur_trail = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_sync = 1'b0;
                in_trail  = 1'b0;
                prep_cnt  = 0;
                trail_cnt = 0;
            end else if (m_hs_req) begin
                if (!seen_sync) begin
                    if (m_lane_valid != 0) begin
                        check_val("sync_data", m_lane_data, 32'hB8B8B8B8);
                        check_val("sync_mask", m_lane_valid, 4'hF);
                        check_val("prep_len", prep_cnt, PREP);
                        seen_sync = 1'b1;
                    end else begin
                        prep_cnt++;
                        check_val("prep_data", m_lane_data, 0);
                    end
                end else if (in_trail) begin
                    trail_cnt++;
                    check_val("trail_data", m_lane_data, cur_trail);
                    check_val("trail_valid", m_lane_valid, 0);
                    check_val("trail_tready", s_axis_tready, 0);
                end else if (m_lane_valid != 0) begin
                    if (exp_q.size() == 0) begin
                        check_val("word_unexpected", m_lane_valid, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check_val("word_data", m_lane_data, w.data);
                        check_val("word_mask", m_lane_valid, w.mask);
                        check_val("word_fs", m_frame_start, w.fs);
                        if (w.last) begin
                            in_trail  = 1'b1;
                            cur_trail = w.trail;
                        end
                    end
                end else begin
                    check_val("idle_fs", m_frame_start, 0);
                end
            end else begin
                if (in_trail) begin
                    check_val("trail_len", trail_cnt, TRAIL);
                end
                seen_sync = 1'b0;
                in_trail  = 1'b0;
                prep_cnt  = 0;
                trail_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        int len;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_hs_req", m_hs_req, 0);
        check_val("rst_valid", m_lane_valid, 0);
        check_val("rst_data", m_lane_data, 0);
        check_val("rst_tready", s_axis_tready, 0);
        check_val("rst_fs", m_frame_start, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8-byte packet, continuous, tuser set
        for (int i = 0; i < 8; i++) pkt[i] = 8'h10 + 8'(i);
        send_pkt(8, 1'b1, -1, -1);
        // 6-byte packet 01..06, partial final word
        for (int i = 0; i < 6; i++) pkt[i] = 8'h01 + 8'(i);
        send_pkt(6, 1'b0, -1, -1);
        // lane 0 ends on 0x80
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44; pkt[4] = 8'h80;
        send_pkt(5, 1'b0, -1, -1);
        // 5-cycle gap mid-word
        for (int i = 0; i < 7; i++) pkt[i] = 8'h20 + 8'(i);
        send_pkt(7, 1'b0, 2, -1);
        // reset mid-DATA, then a clean packet
        for (int i = 0; i < 6; i++) pkt[i] = 8'h30 + 8'(i);
        send_pkt(6, 1'b1, -1, 2);
        pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3;
        send_pkt(3, 1'b1, -1, -1);
        // random packets, back-to-back
        for (int p = 0; p < 6; p++) begin
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
            send_pkt(len, 1'($urandom), -1, -1);
        end

        n = 0;
        while ((exp_q.size() != 0 || m_hs_req) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val("drain_queue", exp_q.size(), 0);
        check_val("drain_hs_req", m_hs_req, 0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
